msx_slot_io_responder: RTL and testbench
========================================

MSX_SLOT_IO_RESPONDER -- requirements
Module: msx_slot_io_responder

Interface
REQ-001 SHALL have parameter IO_BASE, default 8'h88, base I/O port; slot_a[7:2] == IO_BASE[7:2] selects the block.
REQ-002 SHALL have parameter TIMEOUT, default 1023, max clk cycles spent in REQ plus RDATA before abort.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 slot_iorq_n / slot_rd_n / slot_wr_n  input  1 each  asynchronous Z80 strobes, active low.
REQ-006 slot_a  input  8  I/O address from slot.
REQ-007 slot_d_in  input  8  data from slot (write cycles).
REQ-008 slot_d_out  output  8  data to slot (read cycles).
REQ-009 slot_data_dir  output  1  1 = block drives slot_d; 0 = host drives.
REQ-010 slot_wait  output  1  1 = stretch host cycle.
REQ-011 bus_valid  output  1  request to VDP core.
REQ-012 bus_write  output  1  1 = write, 0 = read; valid with bus_valid.
REQ-013 bus_address  output  2  port offset slot_a[1:0].
REQ-014 bus_wdata  output  8  write data.
REQ-015 bus_ready  input  1  core accepts request when bus_valid & bus_ready.
REQ-016 bus_rdata  input  8  read data.
REQ-017 bus_rdata_en  input  1  bus_rdata valid this cycle.

Function
REQ-018 SHALL pass each slot strobe through a 2-FF synchronizer before use.
REQ-019 SHALL define active_wr = ~iorq_s & ~wr_s & rd_s; active_rd = ~iorq_s & ~rd_s & wr_s; both low or both high strobes = no access.
REQ-020 SHALL start a transaction only on the 0->1 transition of (active_wr | active_rd) with address match, in state IDLE; mismatched addresses are ignored and leave all outputs unchanged.
REQ-021 SHALL capture slot_a[1:0] into bus_address and slot_d_in into bus_wdata on the start cycle.
REQ-022 SHALL use states IDLE, REQ, RDATA, HOLD.
REQ-023 IDLE -> REQ on start; slot_wait and bus_valid become 1 on the next cycle (start + 1); bus_write = active_wr.
REQ-024 REQ: hold bus_valid, bus_write, bus_address, bus_wdata stable until bus_valid & bus_ready; then bus_valid = 0 next cycle; write -> HOLD, read -> RDATA.
REQ-025 RDATA: on bus_rdata_en, latch bus_rdata into slot_d_out -> HOLD.
REQ-026 bus_rdata_en in the same cycle as the accepting bus_ready SHALL be taken as read data: RDATA is skipped.
REQ-027 HOLD: slot_wait = 0; for reads slot_data_dir = 1 throughout HOLD; -> IDLE when iorq_s = 1, with slot_data_dir = 0 in the same cycle as the transition.
REQ-028 slot_data_dir SHALL be 1 only in HOLD of a read cycle.
REQ-029 A timeout counter SHALL clear on start and increment in REQ and RDATA.
REQ-030 On reaching TIMEOUT: drop bus_valid, load slot_d_out = 8'hFF for reads, go to HOLD.
REQ-031 A strobe released while in REQ or RDATA SHALL NOT abort the core transaction; HOLD then exits on the next cycle.
REQ-032 Strobes that stay active after HOLD exits SHALL NOT retrigger; a new start needs inactive then active.

Reset
REQ-033 On reset: state = IDLE, slot_wait = 0, slot_data_dir = 0, slot_d_out = 8'hFF, bus_valid = 0, bus_write = 0, bus_address = 0, bus_wdata = 0, counter = 0.
REQ-034 Synchronizers SHALL reset to 1 (inactive), and the previous-active flag SHALL reset to 1. A strobe held low through and after a mid-transaction reset SHALL NOT start a cycle; the in-flight request is dropped.

Verification
REQ-035 Write 8'h0E to port 8'h89, bus_ready tied 1 -> one bus_valid pulse, bus_write = 1, bus_address = 2'd1, bus_wdata = 8'h0E; slot_wait high for 1 cycle.
REQ-036 Read port 8'h88, bus_ready = 1, bus_rdata_en 5 cycles later with 8'hA5 -> slot_wait high until data, then slot_data_dir = 1 and slot_d_out = 8'hA5 until iorq released.
REQ-037 Write to port 8'h98 -> no bus_valid, slot_wait stays 0.
REQ-038 Write to 8'h8A with bus_ready held 0 -> after 1023 cycles bus_valid drops and slot_wait drops; a read under the same condition returns 8'hFF.
REQ-039 Reset asserted in REQ with iorq_n/wr_n still low -> all outputs at reset values, and no new request until the strobes go high and then low again.
REQ-040 Back-to-back write_io sequences (8'h00 then 8'h40 to 8'h89) -> exactly two requests, in order, with correct data.

Source files
------------

// File: rtl/msx_slot_io_responder.sv
// rtl/msx_slot_io_responder.sv - MSX slot I/O port responder bridging Z80 I/O cycles to a core bus
//
// Decodes a 4-port I/O window at IO_BASE, stretches the Z80 cycle with slot_wait
// while a request/response handshake runs on the core bus, then presents read data
// until the host releases IORQ.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   slot_iorq_n/rd_n/wr_n           asynchronous Z80 strobes (active low)
//   slot_a, slot_d_in               slot address and write data
//   slot_d_out, slot_data_dir       read data and drive enable toward the slot
//   slot_wait                       stretches the host cycle
//   bus_valid/write/address/wdata   request toward the core
//   bus_ready                       core accepts the request
//   bus_rdata, bus_rdata_en         read data return from the core
module msx_slot_io_responder #(
  parameter logic [7:0] IO_BASE = 8'h88,
  parameter int         TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  output logic       bus_valid,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic       bus_ready,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    strb_m_q, strb_m_d;   // {iorq, rd, wr}, first synchronizer stage
  logic [2:0]    strb_s_q, strb_s_d;   // second stage, safe to use
  logic [1:0]    settle_q, settle_d;
  logic          prev_active_q, prev_active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    slot_d_out_q, slot_d_out_d;
  logic          slot_data_dir_q, slot_data_dir_d;
  logic          slot_wait_q, slot_wait_d;
  logic          bus_valid_q, bus_valid_d;
  logic          bus_write_q, bus_write_d;
  logic [1:0]    bus_address_q, bus_address_d;
  logic [7:0]    bus_wdata_q, bus_wdata_d;

  logic iorq_s, rd_s, wr_s;
  logic active_wr, active_rd, active, addr_hit, start, timed_out;

  assign iorq_s    = strb_s_q[2];
  assign rd_s      = strb_s_q[1];
  assign wr_s      = strb_s_q[0];
  assign active_wr = ~iorq_s & ~wr_s & rd_s;
  assign active_rd = ~iorq_s & ~rd_s & wr_s;
  assign active    = active_wr | active_rd;
  assign addr_hit  = (slot_a[7:2] == IO_BASE[7:2]);
  assign start     = (state_q == IDLE) & active & ~prev_active_q & addr_hit;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d         = state_q;
    strb_m_d        = {slot_iorq_n, slot_rd_n, slot_wr_n};
    strb_s_d        = strb_m_q;
    settle_d        = {settle_q[0], 1'b1};
    // The synchronizers come out of reset reading "inactive" before they have
    // sampled the real pins; keep the edge detector armed high until both stages
    // hold real samples so a strobe held low across reset cannot look like a new edge.
    prev_active_d   = settle_q[1] ? active : 1'b1;
    cnt_d           = cnt_q;
    slot_d_out_d    = slot_d_out_q;
    slot_data_dir_d = slot_data_dir_q;
    slot_wait_d     = slot_wait_q;
    bus_valid_d     = bus_valid_q;
    bus_write_d     = bus_write_q;
    bus_address_d   = bus_address_q;
    bus_wdata_d     = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = REQ;
          cnt_d         = '0;
          slot_wait_d   = 1'b1;
          bus_valid_d   = 1'b1;
          bus_write_d   = active_wr;
          bus_address_d = slot_a[1:0];
          bus_wdata_d   = slot_d_in;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_valid_q & bus_ready) begin
          bus_valid_d = 1'b0;
          if (bus_write_q) begin
            state_d     = HOLD;
            slot_wait_d = 1'b0;
          end else if (bus_rdata_en) begin
            // Data returned alongside acceptance: no need to wait in RDATA.
            state_d         = HOLD;
            slot_wait_d     = 1'b0;
            slot_d_out_d    = bus_rdata;
            slot_data_dir_d = 1'b1;
          end else begin
            state_d = RDATA;
          end
        end else if (timed_out) begin
          state_d     = HOLD;
          bus_valid_d = 1'b0;
          slot_wait_d = 1'b0;
          if (!bus_write_q) begin
            slot_d_out_d    = 8'hFF;
            slot_data_dir_d = 1'b1;
          end
        end
      end
      RDATA: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rdata_en) begin
          state_d         = HOLD;
          slot_wait_d     = 1'b0;
          slot_d_out_d    = bus_rdata;
          slot_data_dir_d = 1'b1;
        end else if (timed_out) begin
          state_d         = HOLD;
          slot_wait_d     = 1'b0;
          slot_d_out_d    = 8'hFF;
          slot_data_dir_d = 1'b1;
        end
      end
      HOLD: begin
        if (iorq_s) begin
          state_d         = IDLE;
          slot_data_dir_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      strb_m_q        <= 3'b111;
      strb_s_q        <= 3'b111;
      settle_q        <= 2'b00;
      prev_active_q   <= 1'b1;
      cnt_q           <= '0;
      slot_d_out_q    <= 8'hFF;
      slot_data_dir_q <= 1'b0;
      slot_wait_q     <= 1'b0;
      bus_valid_q     <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= 2'd0;
      bus_wdata_q     <= 8'h00;
    end else begin
      state_q         <= state_d;
      strb_m_q        <= strb_m_d;
      strb_s_q        <= strb_s_d;
      settle_q        <= settle_d;
      prev_active_q   <= prev_active_d;
      cnt_q           <= cnt_d;
      slot_d_out_q    <= slot_d_out_d;
      slot_data_dir_q <= slot_data_dir_d;
      slot_wait_q     <= slot_wait_d;
      bus_valid_q     <= bus_valid_d;
      bus_write_q     <= bus_write_d;
      bus_address_q   <= bus_address_d;
      bus_wdata_q     <= bus_wdata_d;
    end
  end

  assign slot_d_out    = slot_d_out_q;
  assign slot_data_dir = slot_data_dir_q;
  assign slot_wait     = slot_wait_q;
  assign bus_valid     = bus_valid_q;
  assign bus_write     = bus_write_q;
  assign bus_address   = bus_address_q;
  assign bus_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_msx_slot_io_responder.sv
// tb/tb_msx_slot_io_responder.sv - directed table-driven bench for msx_slot_io_responder
module tb_msx_slot_io_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slot_iorq_n = 1'b1, slot_rd_n = 1'b1, slot_wr_n = 1'b1;
  logic [7:0] slot_a = 8'h00, slot_d_in = 8'h00;
  logic [7:0] slot_d_out;
  logic       slot_data_dir, slot_wait;
  logic       bus_valid, bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic       bus_ready = 1'b0;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_rdata_en = 1'b0;

  int total = 0;
  int bad = 0;

  logic [10:0] log_q[$];   // accepted requests: {write, address, wdata}

  always #5 clk = ~clk;

  msx_slot_io_responder dut (
    .clk(clk), .reset(reset),
    .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_data_dir(slot_data_dir), .slot_wait(slot_wait),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_rdata_en(bus_rdata_en)
  );

  always @(posedge clk) begin
    if (!reset && bus_valid && bus_ready) log_q.push_back({bus_write, bus_address, bus_wdata});
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       wr;
    logic       ready;
    int         lat;        // cycles from acceptance to bus_rdata_en (0 = same cycle)
    logic [7:0] rdata;
    int         exp_vcyc;   // cycles bus_valid is high
    int         exp_wait;   // cycles slot_wait is high
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic release_strobes();
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int vcyc = 0, wcyc = 0, cnt = 0;
    bit seen = 0, pend = 0, done = 0, unstable = 0;
    logic [10:0] first = '0;
    bus_ready = v.ready;
    slot_a = v.a;
    slot_d_in = v.d;
    slot_iorq_n = 1'b0;
    if (v.wr) slot_wr_n = 1'b0; else slot_rd_n = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      bus_rdata_en = 1'b0;
      if (pend) begin
        if (cnt == 1) begin bus_rdata_en = 1'b1; bus_rdata = v.rdata; pend = 0; end
        else cnt--;
      end
      if (bus_valid) begin
        if (vcyc == 0) first = {bus_write, bus_address, bus_wdata};
        else if (first !== {bus_write, bus_address, bus_wdata}) unstable = 1;
        vcyc++;
        if (bus_ready && !bus_write) begin
          if (v.lat == 0) begin bus_rdata_en = 1'b1; bus_rdata = v.rdata; end
          else begin pend = 1; cnt = v.lat; end
        end
      end
      if (slot_wait) begin wcyc++; seen = 1; end
      if ((seen && !slot_wait) || (!seen && i > 15)) begin done = 1; break; end
    end
    check({tag, "_finished"}, done, 1);
    check({tag, "_valid_cycles"}, vcyc, v.exp_vcyc);
    check({tag, "_wait_cycles"}, wcyc, v.exp_wait);
    if (v.exp_vcyc > 0) begin
      check({tag, "_req"}, first, {v.wr, v.a[1:0], v.d});
      check({tag, "_stable"}, unstable, 0);
    end
    repeat (3) @(negedge clk);
    check({tag, "_dir_hold"}, slot_data_dir, (!v.wr && v.exp_vcyc > 0) ? 1 : 0);
    if (!v.wr && v.exp_vcyc > 0) check({tag, "_dout"}, slot_d_out, v.exp_dout);
    release_strobes();
    repeat (4) @(negedge clk);
    check({tag, "_dir_released"}, slot_data_dir, 0);
  endtask

  task automatic wait_valid(input string tag);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_valid) begin got = 1; break; end
    end
    check({tag, "_valid_seen"}, got, 1);
  endtask

  initial begin
    vec_t v;
    int dcyc, vc;
    logic [7:0] dval;

    //           a      d      wr    rdy   lat rdata  vcyc  wait  dout
    vecs[0] = '{8'h89, 8'h0E, 1'b1, 1'b1, 0, 8'h00, 1,    1,    8'h00};
    vecs[1] = '{8'h88, 8'h00, 1'b0, 1'b1, 5, 8'hA5, 1,    6,    8'hA5};
    vecs[2] = '{8'h98, 8'h12, 1'b1, 1'b1, 0, 8'h00, 0,    0,    8'h00};
    vecs[3] = '{8'h8B, 8'h00, 1'b0, 1'b1, 0, 8'h3C, 1,    1,    8'h3C};
    vecs[4] = '{8'h8A, 8'h66, 1'b1, 1'b0, 0, 8'h00, 1023, 1023, 8'h00};
    vecs[5] = '{8'h8A, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1023, 1023, 8'hFF};
    vecs[6] = '{8'h8B, 8'h5A, 1'b1, 1'b1, 0, 8'h00, 1,    1,    8'h00};
    vecs[7] = '{8'h8C, 8'h00, 1'b0, 1'b1, 0, 8'h99, 0,    0,    8'h00};
    vecs[8] = '{8'h89, 8'h00, 1'b0, 1'b1, 2, 8'h81, 1,    3,    8'h81};

    repeat (3) @(negedge clk);
    check("rst_valid", bus_valid, 0);
    check("rst_wait", slot_wait, 0);
    check("rst_dir", slot_data_dir, 0);
    check("rst_dout", slot_d_out, 8'hFF);
    check("rst_req", {bus_write, bus_address, bus_wdata}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Back-to-back writes to 0x89.
    log_q.delete();
    v = '{8'h89, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1, 1, 8'h00};
    run_vec(v, "b2b_a");
    v.d = 8'h40;
    run_vec(v, "b2b_b");
    check("b2b_count", log_q.size(), 2);
    check("b2b_first", log_q[0], {1'b1, 2'd1, 8'h00});
    check("b2b_second", log_q[1], {1'b1, 2'd1, 8'h40});

    // Strobes released while waiting for read data: core transaction still completes.
    bus_ready = 1'b1;
    slot_a = 8'h88;
    slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    wait_valid("early_rel");
    release_strobes();
    repeat (10) @(negedge clk);
    check("early_rel_wait", slot_wait, 1);
    bus_rdata = 8'h77; bus_rdata_en = 1'b1;
    @(negedge clk);
    bus_rdata_en = 1'b0;
    dcyc = 0; dval = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (slot_data_dir) begin dcyc++; dval = slot_d_out; end
      @(negedge clk);
    end
    check("early_rel_dir_cycles", dcyc, 1);
    check("early_rel_dout", dval, 8'h77);
    check("early_rel_wait_end", slot_wait, 0);

    // Reset in REQ with strobes held low.
    log_q.delete();
    bus_ready = 1'b0;
    slot_a = 8'h89; slot_d_in = 8'h11;
    slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    wait_valid("mid_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", bus_valid, 0);
    check("mid_rst_wait", slot_wait, 0);
    check("mid_rst_dout", slot_d_out, 8'hFF);
    check("mid_rst_req", {bus_write, bus_address, bus_wdata}, 0);
    bus_ready = 1'b1;
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_valid || slot_wait) vc++;
    end
    check("mid_rst_no_retrigger", vc, 0);
    release_strobes();
    repeat (4) @(negedge clk);
    v = '{8'h89, 8'h22, 1'b1, 1'b1, 0, 8'h00, 1, 1, 8'h00};
    run_vec(v, "post_rst");
    check("post_rst_log_count", log_q.size(), 1);
    check("post_rst_log", log_q[0], {1'b1, 2'd1, 8'h22});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
